// File: rtl/ndp_drain_pkg.sv
// rtl/ndp_drain_pkg.sv - shared state encoding, sizing helpers and parameter checks for the result drain
package ndp_drain_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic int n_words(input int res_bits);
        return res_bits / 32;
    endfunction

    // A single-word result still needs a 1-bit index so the port widths stay legal.
    function automatic int idx_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int res_bits);
        return ((width == 8) || (width == 16) || (width == 32)) && ((res_bits % 32) == 0);
    endfunction

endpackage

// File: rtl/ndp_relu_lane.sv
// rtl/ndp_relu_lane.sv - combinational per-element rectifier: negative (sign bit set) elements become zero
module ndp_relu_lane #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] elem_in,
    output logic [WIDTH-1:0] elem_out
);

    assign elem_out = elem_in[WIDTH-1] ? '0 : elem_in;

endmodule

// File: rtl/ndp_result_drain.sv
// rtl/ndp_result_drain.sv - captures NDP_core out_c on calc_done_flag rise and streams it as 32-bit words; NDP_DRAIN_RELU_EN rectifies at capture
module ndp_result_drain
    import ndp_drain_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 64,
    parameter int RES_BITS   = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                calc_done_flag,
    input  logic [RES_BITS-1:0] in_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic                busy,
    output logic                overrun
);

    localparam int N_WORDS = n_words(RES_BITS);
    localparam int IDX_W   = idx_bits(N_WORDS);
    localparam int N_ELEM  = RES_BITS / WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    if (!params_ok(WIDTH, RES_BITS)) begin : g_bad_params
        $error("ndp_result_drain: WIDTH must be 8/16/32 and RES_BITS a multiple of 32");
    end

    logic [RES_BITS-1:0] cap;
    logic [RES_BITS-1:0] cap_d;
    logic [IDX_W-1:0]    idx;
    logic [0:0]          state;
    logic                done_q;
    logic                done_rise;
    logic                handshake;
    logic                at_last;

`ifdef NDP_DRAIN_RELU_EN
    for (genvar e = 0; e < N_ELEM; e++) begin : g_relu
        ndp_relu_lane #(.WIDTH(WIDTH)) u_relu (
            .elem_in  (in_c[e*WIDTH +: WIDTH]),
            .elem_out (cap_d[e*WIDTH +: WIDTH])
        );
    end
`else
    assign cap_d = in_c;
`endif

    assign done_rise = calc_done_flag & ~done_q;
    assign busy      = (state == ST_DRAIN);
    assign out_valid = busy;
    assign at_last   = (idx == LAST_IDX);
    assign out_last  = busy & at_last;
    assign out_data  = busy ? cap[{idx, 5'b00000} +: 32] : 32'h0;
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Held at 1 so a flag left high across reset is not mistaken for a new result.
            done_q  <= 1'b1;
            state   <= ST_IDLE;
            idx     <= '0;
            overrun <= 1'b0;
            cap     <= '0;
        end else begin
            done_q <= calc_done_flag;
            if (state == ST_IDLE) begin
                if (done_rise) begin
                    cap   <= cap_d;
                    idx   <= '0;
                    state <= ST_DRAIN;
                end
            end else begin
                if (handshake && at_last) begin
                    if (done_rise) begin
                        cap <= cap_d;
                        idx <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end else begin
                    if (handshake) begin
                        idx <= idx + 1'b1;
                    end
                    if (done_rise) begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ndp_result_drain.sv
// tb/tb_ndp_result_drain.sv - directed self-checking bench for ndp_result_drain at default parameters
module tb_ndp_result_drain;

    localparam int RES_BITS = 16384;
    localparam int N_WORDS  = 512;
    localparam int N_ELEM   = 1024;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                calc_done_flag = 1'b0;
    logic [RES_BITS-1:0] in_c = '0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [31:0]         out_data;
    logic                out_last;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int failures = 0;
    logic [RES_BITS-1:0] cur;

    ndp_result_drain dut (
        .clk            (clk),
        .reset          (reset),
        .calc_done_flag (calc_done_flag),
        .in_c           (in_c),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RES_BITS-1:0] make_pattern(input int kind);
        logic [RES_BITS-1:0] v;
        v = '0;
        for (int e = 0; e < N_ELEM; e++) begin
            case (kind)
                0: v[e*16 +: 16] = 16'(e);
                1: v[e*16 +: 16] = 16'(e * 3 + 'h1234);
                default: v[e*16 +: 16] = (e % 3 == 0) ? 16'hBC00 : ((e % 3 == 1) ? 16'h8000 : 16'h3C00);
            endcase
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input logic [RES_BITS-1:0] v, input int w);
        logic [31:0] x;
        x = v[32*w +: 32];
`ifdef NDP_DRAIN_RELU_EN
        if (x[15]) x[15:0] = 16'h0;
        if (x[31]) x[31:16] = 16'h0;
`endif
        return x;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        calc_done_flag = 1'b0;
        tick;
        tick;
        checks++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0000 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: valid/last/busy/overrun=%b data=%h required 0000 / 00000000",
                     {out_valid, out_last, busy, overrun}, out_data);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_basic;
        in_c = make_pattern(0);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        for (int w = 0; w < N_WORDS; w++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== {16'(2*w+1), 16'(2*w)}
                || out_last !== (w == N_WORDS - 1)) begin
                failures++;
                $display("FAIL basic_word%0d: valid=%b busy=%b data=%h last=%b required 1 1 %h %b",
                         w, out_valid, busy, out_data, out_last, {16'(2*w+1), 16'(2*w)}, (w == N_WORDS - 1));
            end
            tick;
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: busy=%b valid=%b overrun=%b required 0 0 0", busy, out_valid, overrun);
        end
    endtask

    task automatic test_backpressure;
        int cnt;
        int cyc;
        logic [31:0] prev;
        logic stalled;
        logic hs;
        cnt = 0;
        cyc = 0;
        prev = '0;
        stalled = 1'b0;
        in_c = make_pattern(1);
        cur = in_c;
        out_ready = 1'b0;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        while (cnt < N_WORDS && cyc < 4000) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word(cur, cnt) || out_last !== (cnt == N_WORDS - 1)) begin
                failures++;
                $display("FAIL bp_word%0d: valid=%b data=%h last=%b required 1 %h %b",
                         cnt, out_valid, out_data, out_last, exp_word(cur, cnt), (cnt == N_WORDS - 1));
            end
            if (stalled) begin
                checks++;
                if (out_data !== prev) begin
                    failures++;
                    $display("FAIL bp_stall_hold: data=%h required %h", out_data, prev);
                end
            end
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            prev = out_data;
            stalled = ~out_ready;
            hs = out_valid & out_ready;
            tick;
            cyc++;
            if (hs) cnt++;
        end
        checks++;
        if (cnt != N_WORDS || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_count: handshakes=%0d valid=%b required %0d 0", cnt, out_valid, N_WORDS);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [RES_BITS-1:0] second;
        in_c = make_pattern(0);
        cur = in_c;
        second = make_pattern(1);
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        for (int w = 0; w < N_WORDS - 1; w++) tick;
        checks++;
        if (out_last !== 1'b1 || out_data !== exp_word(cur, N_WORDS - 1)) begin
            failures++;
            $display("FAIL b2b_first_last: last=%b data=%h required 1 %h", out_last, out_data, exp_word(cur, N_WORDS - 1));
        end
        in_c = second;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_word(second, 0) || out_last !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_word0: valid=%b data=%h last=%b overrun=%b required 1 %h 0 0",
                     out_valid, out_data, out_last, overrun, exp_word(second, 0));
        end
        for (int w = 1; w < N_WORDS; w++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word(second, w)) begin
                failures++;
                $display("FAIL b2b_word%0d: valid=%b data=%h required 1 %h", w, out_valid, out_data, exp_word(second, w));
            end
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: valid=%b overrun=%b required 0 0", out_valid, overrun);
        end
    endtask

    task automatic test_overrun;
        in_c = make_pattern(0);
        cur = in_c;
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        for (int w = 0; w < 100; w++) tick;
        checks++;
        if (overrun !== 1'b0 || out_data !== exp_word(cur, 100)) begin
            failures++;
            $display("FAIL ovr_before: overrun=%b data=%h required 0 %h", overrun, out_data, exp_word(cur, 100));
        end
        in_c = make_pattern(1);
        calc_done_flag = 1'b1;
        tick;
        for (int w = 101; w < N_WORDS; w++) begin
            checks++;
            if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_word(cur, w)) begin
                failures++;
                $display("FAIL ovr_word%0d: overrun=%b valid=%b data=%h required 1 1 %h",
                         w, overrun, out_valid, out_data, exp_word(cur, w));
            end
            tick;
        end
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_end: overrun=%b valid=%b required 1 0", overrun, out_valid);
        end
        calc_done_flag = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        in_c = make_pattern(1);
        cur = in_c;
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        for (int w = 0; w < 37; w++) tick;
        checks++;
        if (out_data !== exp_word(cur, 37)) begin
            failures++;
            $display("FAIL rstmid_word37: data=%h required %h", out_data, exp_word(cur, 37));
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({out_valid, out_last, busy, overrun} !== 4'b0000 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs: valid/last/busy/overrun=%b data=%h required 0000 00000000",
                     {out_valid, out_last, busy, overrun}, out_data);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flag_held;
        calc_done_flag = 1'b1;
        reset = 1'b1;
        tick;
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL held_no_capture%0d: out_valid=%b required 0", i, out_valid);
            end
        end
        calc_done_flag = 1'b0;
        tick;
        in_c = make_pattern(0);
        cur = in_c;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_word(cur, 0)) begin
            failures++;
            $display("FAIL held_capture: valid=%b data=%h required 1 %h", out_valid, out_data, exp_word(cur, 0));
        end
        for (int w = 0; w < N_WORDS; w++) tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL held_end: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_relu;
        logic [31:0] w0;
        logic [31:0] w1;
`ifdef NDP_DRAIN_RELU_EN
        w0 = 32'h0000_0000;
        w1 = 32'h0000_3C00;
`else
        w0 = 32'h8000_BC00;
        w1 = 32'hBC00_3C00;
`endif
        in_c = make_pattern(2);
        cur = in_c;
        out_ready = 1'b1;
        calc_done_flag = 1'b1;
        tick;
        calc_done_flag = 1'b0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (w == 0 || w == 1) begin
                checks++;
                if (out_data !== ((w == 0) ? w0 : w1)) begin
                    failures++;
                    $display("FAIL relu_hand%0d: data=%h required %h", w, out_data, (w == 0) ? w0 : w1);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word(cur, w)) begin
                failures++;
                $display("FAIL relu_word%0d: valid=%b data=%h required 1 %h", w, out_valid, out_data, exp_word(cur, w));
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        test_flag_held;
        test_relu;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ndp_result_drain.md
# ndp_result_drain

Downstream stage of `NDP_core`. It captures the full result matrix `out_c` when the core raises `calc_done_flag` and drains it as a stream of 32-bit words over a valid/ready handshake. Word order matches the core's input packing, so the stream can be written straight back to memory or forwarded to the next expert stage. The core is then free to start the next tile while the previous result drains.

## Interface
Parameters:
- `WIDTH`, 16, element width in bits; must be 8, 16 or 32.
- `ARR_HEIGHT`, 4, PE rows per systolic array.
- `ARR_WIDTH`, 4, PE columns per systolic array.
- `SYS_HEIGHT`, 1, systolic arrays vertically.
- `SYS_WIDTH`, 64, systolic arrays horizontally.
- Derived `RES_BITS` = SYS_HEIGHT·ARR_HEIGHT·SYS_WIDTH·ARR_WIDTH·WIDTH; must be a multiple of 32.
- Derived `N_WORDS` = RES_BITS/32 (512 at defaults).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `calc_done_flag`  in  1  from `NDP_core`; level, may stay high for many cycles.
- `in_c`  in  RES_BITS  result matrix from `NDP_core.out_c`; valid whenever `calc_done_flag`=1.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word on a cycle with `out_valid`=1.
- `out_data`  out  32  result word.
- `out_last`  out  1  high with word N_WORDS−1.
- `busy`  out  1  high in DRAIN.
- `overrun`  out  1  sticky; a new result arrived while draining.

## Operation
- `done_q` registers `calc_done_flag`. `done_rise` = `calc_done_flag` & ~`done_q`.
- States:
  - IDLE: waits for `done_rise`.
  - DRAIN: streams words.
- Capture: a `done_rise` in IDLE loads `cap` ← `in_c`, sets `idx`=0 and moves to DRAIN.
- In DRAIN:
  - `out_valid`=1.
  - `out_data` = `cap[32·idx +: 32]`; word 0 is the LSBs.
  - `out_last` = (`idx` == N_WORDS−1).
- Handshake: `out_valid` & `out_ready` advances `idx`.
  - On the last word, return to IDLE.
  - Exception: if `done_rise` occurs in the same cycle as the last handshake, capture the new result, set `idx`=0 and stay in DRAIN. This gives back-to-back drains with no bubble.
- Stall rule: while `out_valid` & ~`out_ready`, `out_data` and `out_last` hold steady. `out_valid` never drops before its handshake.
- A `done_rise` in DRAIN outside the last-handshake cycle:
  - sets `overrun`=1;
  - the new result is dropped;
  - the current drain continues unaffected.
- `idx` width is clog2(N_WORDS). It never wraps in use; it is reset to 0 on each capture.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0.
  - `out_data`=0; IDLE drives 0.
  - `idx`=0, state=IDLE.
  - `done_q`=1, so a flag held high through reset is ignored until it falls and rises again.
- Latency: when `done_rise` is sampled at posedge t, `out_valid`=1 with word 0 from posedge t (visible in cycle t+1).
- Throughput: 1 word/cycle while `out_ready`=1. A full drain takes N_WORDS cycles minimum.
- `out_ready` is ignored while `out_valid`=0.
- Reset mid-drain:
  - abandons the drain; outputs return to their reset values next cycle;
  - captured data is discarded;
  - `overrun` is cleared.

## Configuration
- `NDP_DRAIN_RELU_EN` defined: ReLU is applied per WIDTH-bit element at capture. Any element whose MSB (sign) is 1 is stored as all zeros, including float −0 and int negatives. The result reaches `out_data` already rectified; latency is unchanged.
- Not defined: `cap` = `in_c` bit-exact, with no ReLU logic.

## Structure
- Package `ndp_drain_pkg` holds:
  - the state enum (IDLE, DRAIN);
  - function `n_words(...)` and the `idx` width derivation;
  - elaboration checks: WIDTH ∈ {8,16,32} and RES_BITS % 32 == 0.
- Sub-module `ndp_relu_lane` (param WIDTH): combinational per-element rectifier, generated RES_BITS/WIDTH times. It is instantiated only under `NDP_DRAIN_RELU_EN`.

## Test plan
- Basic drain (defaults, `out_ready`=1):
  - Stimulus: `in_c` element e = e (16-bit), `calc_done_flag` rises.
  - Required: 512 words; word w = {16'(2w+1), 16'(2w)}; `out_last` only on w=511; `busy` falls the next cycle.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1,…
  - Required: `out_data` stable during stalls; no word lost or duplicated; 512 handshakes total.
- Back-to-back:
  - Stimulus: second `done_rise` coincides with the handshake of word 511.
  - Required: word 0 of the second result in the next cycle; `overrun`=0.
- Overrun:
  - Stimulus: `done_rise` at word 100 of a drain.
  - Required: `overrun`=1 and stays set; remaining words come from the first result.
- Reset:
  - Stimulus 1: reset at word 37. Required: `out_valid`=0 next cycle.
  - Stimulus 2: `calc_done_flag` held high through and after reset. Required: no capture until the flag goes 0→1.
- ReLU (`NDP_DRAIN_RELU_EN`):
  - Stimulus: elements 16'hBC00 (−1.0), 16'h8000 (−0) and 16'h3C00.
  - Required: outputs 16'h0000, 16'h0000 and 16'h3C00.
  - Without the macro: all three pass unchanged.
